// File: rtl/lsq_coef_solver.sv
// Solves beta = A*b for a symmetric 3x3 fixed-point A and unsigned integer b.
// A single signed multiplier is time-shared over nine MAC steps, one matrix entry per clock.
module lsq_coef_solver #(
    parameter int AW   = 32,
    parameter int BW   = 33,
    parameter int FRAC = 16,
    parameter int OW   = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [AW-1:0] a00,
    input  logic [AW-1:0] a01,
    input  logic [AW-1:0] a02,
    input  logic [AW-1:0] a11,
    input  logic [AW-1:0] a12,
    input  logic [AW-1:0] a22,
    input  logic [BW-1:0] b0,
    input  logic [BW-1:0] b1,
    input  logic [BW-1:0] b2,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [OW-1:0] beta0,
    output logic [OW-1:0] beta1,
    output logic [OW-1:0] beta2,
    output logic          busy
);
    localparam int PW   = AW + BW + 1;
    localparam int ACCW = AW + BW + 3;
    localparam logic signed [ACCW-1:0] HALF = ACCW'(1) << (FRAC - 1);
    localparam logic signed [ACCW-1:0] OMAX = {{(ACCW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [ACCW-1:0] OMIN = {{(ACCW-OW+1){1'b1}}, {(OW-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

    state_t state, state_next;

    logic [AW-1:0] r00, r01, r02, r11, r12, r22;
    logic [BW-1:0] rb [3];
    logic [OW-1:0] beta_q [3];
    logic [1:0]    row, col;
    logic signed [ACCW-1:0] acc;

    logic signed [AW-1:0]   a_sel;
    logic signed [BW:0]     b_ext;
    logic signed [PW-1:0]   prod;
    logic signed [ACCW-1:0] sum, rounded, shifted;
    logic [OW-1:0]          sat_val;

    // Symmetric lookup: only the upper triangle is stored.
    always_comb begin
        a_sel = r22;
        case ({row, col})
            4'b0000:          a_sel = r00;
            4'b0001, 4'b0100: a_sel = r01;
            4'b0010, 4'b1000: a_sel = r02;
            4'b0101:          a_sel = r11;
            4'b0110, 4'b1001: a_sel = r12;
            default:          a_sel = r22;
        endcase
    end

    assign b_ext   = {1'b0, rb[col]};
    assign prod    = a_sel * b_ext;
    assign sum     = acc + {{(ACCW-PW){prod[PW-1]}}, prod};
    assign rounded = sum + HALF;
    assign shifted = rounded >>> FRAC;

    always_comb begin
        sat_val = shifted[OW-1:0];
        if (shifted > OMAX)
            sat_val = OMAX[OW-1:0];
        else if (shifted < OMIN)
            sat_val = OMIN[OW-1:0];
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = MAC;
            MAC:     if (row == 2'd2 && col == 2'd2) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            acc    <= '0;
            row    <= '0;
            col    <= '0;
            r00    <= '0;
            r01    <= '0;
            r02    <= '0;
            r11    <= '0;
            r12    <= '0;
            r22    <= '0;
            for (int i = 0; i < 3; i++) begin
                rb[i]     <= '0;
                beta_q[i] <= '0;
            end
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        r00   <= a00;
                        r01   <= a01;
                        r02   <= a02;
                        r11   <= a11;
                        r12   <= a12;
                        r22   <= a22;
                        rb[0] <= b0;
                        rb[1] <= b1;
                        rb[2] <= b2;
                        acc   <= '0;
                        row   <= '0;
                        col   <= '0;
                    end
                end
                MAC: begin
                    // Last column of a row: commit the rounded, saturated result.
                    if (col == 2'd2) begin
                        beta_q[row] <= sat_val;
                        acc         <= '0;
                        col         <= '0;
                        row         <= (row == 2'd2) ? 2'd0 : row + 2'd1;
                    end else begin
                        acc <= sum;
                        col <= col + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign beta0     = beta_q[0];
    assign beta1     = beta_q[1];
    assign beta2     = beta_q[2];

endmodule

// File: tb/tb_lsq_coef_solver.sv
// Directed bench for lsq_coef_solver: expected betas are round-half-up(sum A_ij*b_j / 2^16),
// saturated to 32 bits, computed by hand for each vector.
module tb_lsq_coef_solver;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a00 = '0, a01 = '0, a02 = '0, a11 = '0, a12 = '0, a22 = '0;
    logic [32:0] b0 = '0, b1 = '0, b2 = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] beta0, beta1, beta2;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int lat;

    lsq_coef_solver dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a00       (a00),
        .a01       (a01),
        .a02       (a02),
        .a11       (a11),
        .a12       (a12),
        .a22       (a22),
        .b0        (b0),
        .b1        (b1),
        .b2        (b2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .beta0     (beta0),
        .beta1     (beta1),
        .beta2     (beta2),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ops(input logic [31:0] x00, x01, x02, x11, x12, x22,
                           input logic [32:0] y0, y1, y2);
        a00 = x00; a01 = x01; a02 = x02; a11 = x11; a12 = x12; a22 = x22;
        b0 = y0; b1 = y1; b2 = y2;
    endtask

    task automatic accept();
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("accept_ready", in_ready, 1'b1);
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_done(output int l);
        l = 0;
        forever begin
            @(negedge clk);
            if (out_valid || l > 40) break;
            l++;
        end
    endtask

    task automatic release_result();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check("release_out_valid", out_valid, 1'b0);
        check("release_in_ready", in_ready, 1'b1);
    endtask

    task automatic check_betas(input string tag, input logic [31:0] e0, e1, e2);
        check({tag, "_beta0"}, beta0, e0);
        check({tag, "_beta1"}, beta1, e1);
        check({tag, "_beta2"}, beta2, e2);
    endtask

    initial begin
        // Reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check_betas("rst", 32'd0, 32'd0, 32'd0);

        // Identity: 65536*b / 65536 = b; latency 9
        set_ops(32'd65536, 32'd0, 32'd0, 32'd65536, 32'd0, 32'd65536, 33'd5, 33'd7, 33'd9);
        accept();
        wait_done(lat);
        check("ident_latency", lat, 9);
        check("ident_busy", busy, 1'b1);
        check("ident_in_ready", in_ready, 1'b0);
        check_betas("ident", 32'd5, 32'd7, 32'd9);
        release_result();

        // Symmetric fill: rows sum to 262144, 196608, 131072 -> 4, 3, 2
        set_ops(32'd65536, 32'd32768, 32'd0, 32'd131072, -32'sd65536, 32'd65536,
                33'd2, 33'd4, 33'd6);
        accept();
        set_ops('0, '0, '0, '0, '0, '0, '0, '0, '0);
        wait_done(lat);
        check("sym_latency", lat, 9);
        check_betas("sym", 32'd4, 32'd3, 32'd2);
        release_result();

        // Rounding: -32768 + 32768 = 0 -> 0
        set_ops(-32'sd32768, '0, '0, '0, '0, '0, 33'd1, '0, '0);
        accept();
        wait_done(lat);
        check_betas("rnd_half", 32'd0, 32'd0, 32'd0);
        release_result();

        // Rounding: -98304 + 32768 = -65536 -> -1
        set_ops(-32'sd98304, '0, '0, '0, '0, '0, 33'd1, '0, '0);
        accept();
        wait_done(lat);
        check_betas("rnd_neg", 32'hFFFF_FFFF, 32'd0, 32'd0);
        release_result();

        // Positive saturation
        set_ops(32'h7FFF_FFFF, '0, '0, '0, '0, '0, 33'h1_FFFF_FFFF, '0, '0);
        accept();
        wait_done(lat);
        check_betas("sat_pos", 32'h7FFF_FFFF, 32'd0, 32'd0);
        release_result();

        // Negative saturation
        set_ops(32'h8000_0000, '0, '0, '0, '0, '0, 33'h1_FFFF_FFFF, '0, '0);
        accept();
        wait_done(lat);
        check_betas("sat_neg", 32'h8000_0000, 32'd0, 32'd0);
        release_result();

        // Backpressure: hold result 20 clocks while in_valid pulses with other operands
        set_ops(32'd65536, '0, '0, 32'd65536, '0, 32'd65536, 33'd11, 33'd12, 33'd13);
        accept();
        wait_done(lat);
        check("bp_latency", lat, 9);
        set_ops(32'd131072, '0, '0, 32'd131072, '0, 32'd131072, 33'd1, 33'd1, 33'd1);
        for (int i = 0; i < 20; i++) begin
            in_valid = i[0];
            @(negedge clk);
            check("bp_out_valid", out_valid, 1'b1);
            check("bp_in_ready", in_ready, 1'b0);
        end
        in_valid = 1'b0;
        check_betas("bp_hold", 32'd11, 32'd12, 32'd13);
        release_result();
        @(negedge clk);
        check("bp_idle_busy", busy, 1'b0);
        check("bp_no_new_accept", out_valid, 1'b0);

        // Back-to-back with out_ready high: one result every 11 clocks
        set_ops(32'd65536, '0, '0, 32'd65536, '0, 32'd65536, 33'd3, 33'd4, 33'd5);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("b2b_first", out_valid, 1'b1);
        check_betas("b2b", 32'd3, 32'd4, 32'd5);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 40);
        in_valid = 1'b0;
        check("b2b_period", lat, 11);
        @(negedge clk);
        out_ready = 1'b0;
        check("b2b_idle", in_ready, 1'b1);

        // Reset mid-MAC at step 4
        set_ops(32'd65536, '0, '0, 32'd65536, '0, 32'd65536, 33'd5, 33'd7, 33'd9);
        accept();
        repeat (5) @(negedge clk);
        check("mid_busy", busy, 1'b1);
        check("mid_row0_written", beta0, 32'd5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_in_ready", in_ready, 1'b1);
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check_betas("mid_rst", 32'd0, 32'd0, 32'd0);
        repeat (12) @(negedge clk);
        check("mid_rst_no_output", out_valid, 1'b0);

        // Fresh identity solve after reset
        accept();
        wait_done(lat);
        check("post_rst_latency", lat, 9);
        check_betas("post_rst", 32'd5, 32'd7, 32'd9);
        release_result();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
